// File: rtl/dcache_req_arb_pkg.sv
// Shared types and helpers for the D-cache request arbiter.
package dcache_req_arb_pkg;

    localparam int DC_NUM_REQS  = 2;
    localparam int DC_NUM_LANES = 4;
    localparam int DC_ADDRW     = 30;
    localparam int DC_DATAW     = 32;
    localparam int DC_TAG_IN_W  = 12;

    // Width of the requester index appended below the tag; never narrower than one bit.
    function automatic int calc_sel_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int DC_SEL_W     = calc_sel_w(DC_NUM_REQS);
    localparam int DC_TAG_OUT_W = DC_TAG_IN_W + DC_SEL_W;

    // One lane of a requester's request.
    typedef struct packed {
        logic                   rw;
        logic [DC_ADDRW-1:0]    addr;
        logic [3:0]             byteen;
        logic [DC_DATAW-1:0]    data;
        logic [DC_TAG_IN_W-1:0] tag;
    } req_lane_t;

    // One lane of a cache response.
    typedef struct packed {
        logic                valid;
        logic [DC_DATAW-1:0] data;
    } rsp_lane_t;

endpackage

// File: rtl/dcache_req_arb_rr_lock_arbiter.sv
// Round-robin arbiter that locks onto a requester until all of its valid
// lanes have been accepted by the cache.
module dcache_req_arb_rr_lock_arbiter
    import dcache_req_arb_pkg::*;
#(
    parameter int NUM_REQS = DC_NUM_REQS,
    localparam int SEL_W   = calc_sel_w(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] active,
    input  logic                done,
    input  logic                partial,
    output logic [SEL_W-1:0]    grant_idx,
    output logic [NUM_REQS-1:0] grant_onehot
);

    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             locked_q, locked_d;
    logic [SEL_W-1:0] grant_q, grant_d;

    logic [SEL_W-1:0] rr_grant;
    logic             rr_found;
    logic             grant_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
            locked_q <= 1'b0;
            grant_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            locked_q <= locked_d;
            grant_q  <= grant_d;
        end
    end

    // Round-robin search: first active requester at or after rr_ptr.
    always_comb begin
        rr_grant = '0;
        rr_found = 1'b0;
        for (int k = 0; k < NUM_REQS; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQS) idx = idx - NUM_REQS;
            if (!rr_found && active[idx]) begin
                rr_found = 1'b1;
                rr_grant = SEL_W'(idx);
            end
        end
    end

    // Output: a lock pins the grant, otherwise take the round-robin winner.
    always_comb begin
        if (locked_q) begin
            grant_idx   = grant_q;
            grant_valid = active[grant_q];
        end else begin
            grant_idx   = rr_grant;
            grant_valid = rr_found;
        end
        for (int i = 0; i < NUM_REQS; i++) begin
            grant_onehot[i] = grant_valid && (grant_idx == SEL_W'(i));
        end
    end

    // Next state: advance the pointer on completion, lock on a partial fire,
    // release a lock whose owner has withdrawn.
    always_comb begin
        int nxt;
        rr_ptr_d = rr_ptr_q;
        locked_d = locked_q;
        grant_d  = grant_q;
        nxt      = int'(grant_idx) + 1;
        if (nxt >= NUM_REQS) nxt = 0;
        if (grant_valid && done) begin
            locked_d = 1'b0;
            rr_ptr_d = SEL_W'(nxt);
        end else if (grant_valid && partial) begin
            locked_d = 1'b1;
            grant_d  = grant_idx;
        end else if (locked_q && !grant_valid) begin
            locked_d = 1'b0;
        end
    end

    // A locked requester must keep presenting its unsent lanes.
    assert property (@(posedge clk) disable iff (reset) locked_q |-> active[grant_q]);

endmodule

// File: rtl/dcache_req_arb.sv
// Shares one per-lane D-cache port among several lane-parallel requesters.
// Requests pass through combinationally; responses go through a one-entry
// registered stage and are routed by the index carried in the tag LSBs.
module dcache_req_arb
    import dcache_req_arb_pkg::*;
#(
    parameter int NUM_REQS   = DC_NUM_REQS,
    parameter int NUM_LANES  = DC_NUM_LANES,
    parameter int ADDRW      = DC_ADDRW,
    parameter int DATAW      = DC_DATAW,
    parameter int TAG_IN_W   = DC_TAG_IN_W,
    localparam int SEL_W     = calc_sel_w(NUM_REQS),
    localparam int TAG_OUT_W = TAG_IN_W + SEL_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQS*NUM_LANES-1:0]       req_valid_in,
    input  logic [NUM_REQS*NUM_LANES-1:0]       req_rw_in,
    input  logic [NUM_REQS*NUM_LANES*ADDRW-1:0] req_addr_in,
    input  logic [NUM_REQS*NUM_LANES*4-1:0]     req_byteen_in,
    input  logic [NUM_REQS*NUM_LANES*DATAW-1:0] req_data_in,
    input  logic [NUM_REQS*NUM_LANES*TAG_IN_W-1:0] req_tag_in,
    output logic [NUM_REQS*NUM_LANES-1:0]       req_ready_out,
    output logic [NUM_LANES-1:0]                dc_req_valid,
    output logic [NUM_LANES-1:0]                dc_req_rw,
    output logic [NUM_LANES*ADDRW-1:0]          dc_req_addr,
    output logic [NUM_LANES*4-1:0]              dc_req_byteen,
    output logic [NUM_LANES*DATAW-1:0]          dc_req_data,
    output logic [NUM_LANES*TAG_OUT_W-1:0]      dc_req_tag,
    input  logic [NUM_LANES-1:0]                dc_req_ready,
    input  logic                                dc_rsp_valid,
    input  logic [NUM_LANES-1:0]                dc_rsp_tmask,
    input  logic [NUM_LANES*DATAW-1:0]          dc_rsp_data,
    input  logic [TAG_OUT_W-1:0]                dc_rsp_tag,
    output logic                                dc_rsp_ready,
    output logic [NUM_REQS-1:0]                 rsp_valid_out,
    output logic [NUM_LANES-1:0]                rsp_tmask_out,
    output logic [NUM_LANES*DATAW-1:0]          rsp_data_out,
    output logic [TAG_IN_W-1:0]                 rsp_tag_out,
    input  logic [NUM_REQS-1:0]                 rsp_ready_in
);

    // Handshake: a lane transfers on a cycle where its valid and ready are
    // both high; valid never waits on ready, and ready may depend on valid.

    logic [NUM_REQS-1:0]  req_active;
    logic [SEL_W-1:0]     grant_idx;
    logic [NUM_REQS-1:0]  grant_onehot;
    logic [NUM_LANES-1:0] lane_fire;
    logic [NUM_LANES-1:0] lane_stall;
    logic                 req_done;
    logic                 req_partial;

    // Requester is active when any of its lanes is valid.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            req_active[i] = |req_valid_in[i*NUM_LANES +: NUM_LANES];
        end
    end

    dcache_req_arb_rr_lock_arbiter #(
        .NUM_REQS (NUM_REQS)
    ) u_arbiter (
        .clk          (clk),
        .reset        (reset),
        .active       (req_active),
        .done         (req_done),
        .partial      (req_partial),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot)
    );

    // Grant mux: forward the granted requester's lanes and route ready back to it only.
    always_comb begin
        dc_req_valid  = '0;
        dc_req_rw     = '0;
        dc_req_addr   = '0;
        dc_req_byteen = '0;
        dc_req_data   = '0;
        dc_req_tag    = '0;
        req_ready_out = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                req_ready_out[i*NUM_LANES+l] = grant_onehot[i] & dc_req_ready[l];
                if (grant_onehot[i]) begin
                    dc_req_valid[l]                      = req_valid_in[i*NUM_LANES+l];
                    dc_req_rw[l]                         = req_rw_in[i*NUM_LANES+l];
                    dc_req_addr[l*ADDRW +: ADDRW]        = req_addr_in[(i*NUM_LANES+l)*ADDRW +: ADDRW];
                    dc_req_byteen[l*4 +: 4]              = req_byteen_in[(i*NUM_LANES+l)*4 +: 4];
                    dc_req_data[l*DATAW +: DATAW]        = req_data_in[(i*NUM_LANES+l)*DATAW +: DATAW];
                    dc_req_tag[l*TAG_OUT_W +: TAG_OUT_W] =
                        {req_tag_in[(i*NUM_LANES+l)*TAG_IN_W +: TAG_IN_W], grant_idx};
                end
            end
        end
    end

    // Completion when every valid lane fires together; partial when some but not all fire.
    always_comb begin
        lane_fire   = dc_req_valid & dc_req_ready;
        lane_stall  = dc_req_valid & ~dc_req_ready;
        req_done    = (|dc_req_valid) & ~(|lane_stall);
        req_partial = (|lane_fire) & (|lane_stall);
    end

    // ---------------- response stage ----------------

    logic                     r_valid_q, r_valid_d;
    logic [SEL_W-1:0]         r_sel_q, r_sel_d;
    logic [NUM_LANES-1:0]     r_tmask_q, r_tmask_d;
    logic [NUM_LANES*DATAW-1:0] r_data_q, r_data_d;
    logic [TAG_IN_W-1:0]      r_tag_q, r_tag_d;

    logic                     sel_ready;
    logic [SEL_W-1:0]         rsp_sel_in;
    logic                     rsp_sel_ok;
    logic                     rsp_push;
    logic                     rsp_pop;

    // Response entry register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_q <= 1'b0;
            r_sel_q   <= '0;
            r_tmask_q <= '0;
            r_data_q  <= '0;
            r_tag_q   <= '0;
        end else begin
            r_valid_q <= r_valid_d;
            r_sel_q   <= r_sel_d;
            r_tmask_q <= r_tmask_d;
            r_data_q  <= r_data_d;
            r_tag_q   <= r_tag_d;
        end
    end

    // Pop/push control: the entry accepts a new response in the same cycle it drains.
    always_comb begin
        sel_ready = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (r_sel_q == SEL_W'(i)) sel_ready = rsp_ready_in[i];
        end
        rsp_sel_in   = dc_rsp_tag[SEL_W-1:0];
        rsp_sel_ok   = int'(rsp_sel_in) < NUM_REQS;
        rsp_pop      = r_valid_q & sel_ready;
        dc_rsp_ready = ~r_valid_q | sel_ready;
        rsp_push     = dc_rsp_valid & dc_rsp_ready & rsp_sel_ok;

        r_valid_d = rsp_push | (r_valid_q & ~rsp_pop);
        r_sel_d   = r_sel_q;
        r_tmask_d = r_tmask_q;
        r_data_d  = r_data_q;
        r_tag_d   = r_tag_q;
        if (rsp_push) begin
            r_sel_d   = rsp_sel_in;
            r_tmask_d = dc_rsp_tmask;
            r_data_d  = dc_rsp_data;
            r_tag_d   = dc_rsp_tag[TAG_OUT_W-1:SEL_W];
        end
    end

    // Registered response outputs, valid raised only toward the owning requester.
    always_comb begin
        for (int i = 0; i < NUM_REQS; i++) begin
            rsp_valid_out[i] = r_valid_q && (r_sel_q == SEL_W'(i));
        end
        rsp_tmask_out = r_tmask_q;
        rsp_data_out  = r_data_q;
        rsp_tag_out   = r_tag_q;
    end

    // Responses carrying an out-of-range requester index are discarded.
    assert property (@(posedge clk) disable iff (reset) (dc_rsp_valid && dc_rsp_ready) |-> rsp_sel_ok);

endmodule

// File: tb/tb_dcache_req_arb.sv
// Directed bench for dcache_req_arb: vector table for arbitration and
// hand-written sequences for response routing, backpressure and reset.
module tb_dcache_req_arb;
    import dcache_req_arb_pkg::*;

    localparam int NR  = 2;
    localparam int NL  = 4;
    localparam int AW  = 30;
    localparam int DW  = 32;
    localparam int TW  = 12;
    localparam int SW  = calc_sel_w(NR);
    localparam int TOW = TW + SW;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NR*NL-1:0]     req_valid_in;
    logic [NR*NL-1:0]     req_rw_in;
    logic [NR*NL*AW-1:0]  req_addr_in;
    logic [NR*NL*4-1:0]   req_byteen_in;
    logic [NR*NL*DW-1:0]  req_data_in;
    logic [NR*NL*TW-1:0]  req_tag_in;
    logic [NR*NL-1:0]     req_ready_out;
    logic [NL-1:0]        dc_req_valid;
    logic [NL-1:0]        dc_req_rw;
    logic [NL*AW-1:0]     dc_req_addr;
    logic [NL*4-1:0]      dc_req_byteen;
    logic [NL*DW-1:0]     dc_req_data;
    logic [NL*TOW-1:0]    dc_req_tag;
    logic [NL-1:0]        dc_req_ready;
    logic                 dc_rsp_valid;
    logic [NL-1:0]        dc_rsp_tmask;
    logic [NL*DW-1:0]     dc_rsp_data;
    logic [TOW-1:0]       dc_rsp_tag;
    logic                 dc_rsp_ready;
    logic [NR-1:0]        rsp_valid_out;
    logic [NL-1:0]        rsp_tmask_out;
    logic [NL*DW-1:0]     rsp_data_out;
    logic [TW-1:0]        rsp_tag_out;
    logic [NR-1:0]        rsp_ready_in;

    dcache_req_arb #(
        .NUM_REQS (NR), .NUM_LANES (NL), .ADDRW (AW), .DATAW (DW), .TAG_IN_W (TW)
    ) dut (
        .clk (clk), .reset (reset),
        .req_valid_in (req_valid_in), .req_rw_in (req_rw_in), .req_addr_in (req_addr_in),
        .req_byteen_in (req_byteen_in), .req_data_in (req_data_in), .req_tag_in (req_tag_in),
        .req_ready_out (req_ready_out),
        .dc_req_valid (dc_req_valid), .dc_req_rw (dc_req_rw), .dc_req_addr (dc_req_addr),
        .dc_req_byteen (dc_req_byteen), .dc_req_data (dc_req_data), .dc_req_tag (dc_req_tag),
        .dc_req_ready (dc_req_ready),
        .dc_rsp_valid (dc_rsp_valid), .dc_rsp_tmask (dc_rsp_tmask), .dc_rsp_data (dc_rsp_data),
        .dc_rsp_tag (dc_rsp_tag), .dc_rsp_ready (dc_rsp_ready),
        .rsp_valid_out (rsp_valid_out), .rsp_tmask_out (rsp_tmask_out),
        .rsp_data_out (rsp_data_out), .rsp_tag_out (rsp_tag_out), .rsp_ready_in (rsp_ready_in)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Per-requester stimulus values for every lane.
    function automatic logic [TW-1:0] tag_of(input int g);
        return (g == 0) ? 12'h005 : 12'h0C1;
    endfunction

    function automatic req_lane_t lane_of(input int g, input int l);
        req_lane_t s;
        s.rw     = (g == 1);
        s.addr   = AW'(32'h1000 + g * 16 + l);
        s.byteen = (g == 0) ? 4'hF : 4'h3;
        s.data   = 32'hA000_0000 | (g << 8) | l;
        s.tag    = tag_of(g);
        return s;
    endfunction

    function automatic logic [NL*TOW-1:0] exp_tag(input int g);
        logic [NL*TOW-1:0] r;
        logic [SW-1:0]     s;
        s = SW'(g);
        for (int l = 0; l < NL; l++) r[l*TOW +: TOW] = {tag_of(g), s};
        return r;
    endfunction

    function automatic logic [NL*AW-1:0] exp_addr(input int g);
        logic [NL*AW-1:0] r;
        for (int l = 0; l < NL; l++) r[l*AW +: AW] = AW'(32'h1000 + g * 16 + l);
        return r;
    endfunction

    function automatic logic [NL*DW-1:0] exp_data(input int g);
        logic [NL*DW-1:0] r;
        for (int l = 0; l < NL; l++) r[l*DW +: DW] = 32'hA000_0000 | (g << 8) | l;
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic [NL-1:0] v0, input logic [NL-1:0] v1, input logic [NL-1:0] rdy);
        req_valid_in = {v1, v0};
        dc_req_ready = rdy;
    endtask

    task automatic drive_rsp(input logic v, input logic [TW-1:0] tag, input logic [SW-1:0] sel,
                             input logic [NL-1:0] tmask, input logic [DW-1:0] d0);
        dc_rsp_valid = v;
        dc_rsp_tag   = {tag, sel};
        dc_rsp_tmask = tmask;
        dc_rsp_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, d0};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [NL-1:0]    v0;
        logic [NL-1:0]    v1;
        logic [NL-1:0]    rdy;
        logic [NL-1:0]    exp_dcv;
        logic [NR*NL-1:0] exp_ro;
        int               exp_g;
    } vec_t;

    vec_t vecs[16];

    initial begin
        req_lane_t s;

        vecs[0]  = '{4'h0, 4'h0, 4'hF, 4'h0, 8'h00, -1}; // idle
        vecs[1]  = '{4'hF, 4'h0, 4'hF, 4'hF, 8'h0F,  0}; // single requester 0
        vecs[2]  = '{4'hF, 4'hF, 4'hF, 4'hF, 8'hF0,  1}; // pointer moved to 1
        vecs[3]  = '{4'hF, 4'hF, 4'hF, 4'hF, 8'h0F,  0}; // alternation
        vecs[4]  = '{4'hF, 4'hF, 4'hF, 4'hF, 8'hF0,  1};
        vecs[5]  = '{4'hF, 4'hF, 4'hF, 4'hF, 8'h0F,  0};
        vecs[6]  = '{4'hF, 4'hF, 4'hF, 4'hF, 8'hF0,  1};
        vecs[7]  = '{4'hF, 4'hF, 4'h3, 4'hF, 8'h03,  0}; // partial fire, lock on 0
        vecs[8]  = '{4'hC, 4'hF, 4'h3, 4'hC, 8'h03,  0}; // locked, nothing fires
        vecs[9]  = '{4'hC, 4'hF, 4'hC, 4'hC, 8'h0C,  0}; // remainder fires, unlock
        vecs[10] = '{4'hF, 4'hF, 4'hF, 4'hF, 8'hF0,  1}; // next grant to 1
        vecs[11] = '{4'h0, 4'hA, 4'h2, 4'hA, 8'h20,  1}; // partial fire, lock on 1
        vecs[12] = '{4'hF, 4'h8, 4'hF, 4'h8, 8'hF0,  1}; // lock beats pointer at 0
        vecs[13] = '{4'hF, 4'hF, 4'h0, 4'hF, 8'h00,  0}; // no fire, no state change
        vecs[14] = '{4'h0, 4'h4, 4'h4, 4'h4, 8'h40,  1}; // only 1 active
        vecs[15] = '{4'h1, 4'h1, 4'h1, 4'h1, 8'h01,  0}; // pointer back to 0

        for (int g = 0; g < NR; g++) begin
            for (int l = 0; l < NL; l++) begin
                s = lane_of(g, l);
                req_rw_in[g*NL+l]                = s.rw;
                req_addr_in[(g*NL+l)*AW +: AW]   = s.addr;
                req_byteen_in[(g*NL+l)*4 +: 4]   = s.byteen;
                req_data_in[(g*NL+l)*DW +: DW]   = s.data;
                req_tag_in[(g*NL+l)*TW +: TW]    = s.tag;
            end
        end

        reset        = 1'b1;
        drive_req(4'h0, 4'h0, 4'h0);
        drive_rsp(1'b0, 12'h000, 1'b0, 4'h0, 32'h0);
        rsp_ready_in = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;

        // Reset state.
        check("reset_dc_rsp_ready", dc_rsp_ready, 1'b1);
        check("reset_rsp_valid_out", rsp_valid_out, 2'b00);
        check("reset_dc_req_valid", dc_req_valid, 4'h0);

        // Arbitration vectors, one per cycle.
        for (int i = 0; i < 16; i++) begin
            drive_req(vecs[i].v0, vecs[i].v1, vecs[i].rdy);
            #2;
            check($sformatf("v%0d_dc_req_valid", i), dc_req_valid, vecs[i].exp_dcv);
            check($sformatf("v%0d_req_ready_out", i), req_ready_out, vecs[i].exp_ro);
            if (vecs[i].exp_g >= 0) begin
                check($sformatf("v%0d_dc_req_tag", i), dc_req_tag, exp_tag(vecs[i].exp_g));
                check($sformatf("v%0d_dc_req_addr", i), dc_req_addr, exp_addr(vecs[i].exp_g));
                check($sformatf("v%0d_dc_req_data", i), dc_req_data, exp_data(vecs[i].exp_g));
                check($sformatf("v%0d_dc_req_rw", i), dc_req_rw, (vecs[i].exp_g == 1) ? 4'hF : 4'h0);
                check($sformatf("v%0d_dc_req_byteen", i), dc_req_byteen,
                      (vecs[i].exp_g == 1) ? 16'h3333 : 16'hFFFF);
            end
            step();
        end

        // Response routing: tag {0x0A3, 1}.
        drive_req(4'h0, 4'h0, 4'h0);
        drive_rsp(1'b1, 12'h0A3, 1'b1, 4'b0101, 32'hDEAD_BEEF);
        rsp_ready_in = 2'b00;
        #1;
        check("rsp_empty_ready", dc_rsp_ready, 1'b1);
        step();
        check("rsp1_valid_out", rsp_valid_out, 2'b10);
        check("rsp1_tag_out", rsp_tag_out, 12'h0A3);
        check("rsp1_tmask_out", rsp_tmask_out, 4'b0101);
        check("rsp1_data_out", rsp_data_out, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF});
        check("rsp1_full_ready", dc_rsp_ready, 1'b0);

        // Backpressure: a new response for requester 0 must not disturb the entry.
        drive_rsp(1'b1, 12'h055, 1'b0, 4'b1010, 32'h1234_5678);
        #1;
        check("bp_dc_rsp_ready", dc_rsp_ready, 1'b0);
        step();
        check("bp_hold_valid_out", rsp_valid_out, 2'b10);
        check("bp_hold_tag_out", rsp_tag_out, 12'h0A3);
        check("bp_hold_tmask_out", rsp_tmask_out, 4'b0101);

        // Pop and reload in one cycle.
        rsp_ready_in = 2'b10;
        #1;
        check("popload_dc_rsp_ready", dc_rsp_ready, 1'b1);
        step();
        check("popload_valid_out", rsp_valid_out, 2'b01);
        check("popload_tag_out", rsp_tag_out, 12'h055);
        check("popload_tmask_out", rsp_tmask_out, 4'b1010);
        check("popload_data_lane0", rsp_data_out[DW-1:0], 32'h1234_5678);

        // Drain.
        drive_rsp(1'b0, 12'h000, 1'b0, 4'h0, 32'h0);
        rsp_ready_in = 2'b01;
        step();
        check("drain_valid_out", rsp_valid_out, 2'b00);
        check("drain_dc_rsp_ready", dc_rsp_ready, 1'b1);

        // Reset during a lock (pointer is at 1) with a response buffered.
        rsp_ready_in = 2'b00;
        drive_req(4'hF, 4'hF, 4'h3);
        drive_rsp(1'b1, 12'h0A3, 1'b1, 4'b0101, 32'hDEAD_BEEF);
        #2;
        check("prelock_dc_req_tag", dc_req_tag, exp_tag(1));
        step();
        check("prelock_rsp_valid_out", rsp_valid_out, 2'b10);
        check("locked_req_ready_out", req_ready_out, 8'h30);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive_rsp(1'b0, 12'h000, 1'b0, 4'h0, 32'h0);
        drive_req(4'hF, 4'hF, 4'hF);
        #1;
        check("postrst_rsp_valid_out", rsp_valid_out, 2'b00);
        check("postrst_dc_rsp_ready", dc_rsp_ready, 1'b1);
        check("postrst_dc_req_tag", dc_req_tag, exp_tag(0));
        check("postrst_req_ready_out", req_ready_out, 8'h0F);
        step();
        drive_req(4'h0, 4'h0, 4'h0);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dcache_req_arb.md
Name: dcache_req_arb

Overview:
- Shares one per-lane D-cache request/response port among NUM_REQS lane-parallel requesters (slot 0 = LSU, slot 1 = texture unit).
- Requests are forwarded combinationally, so the grant adds no cycle.
- The requester index is appended below the requester's tag on every request, and is used to route each response back.
- Responses go through a one-entry registered stage, which keeps the LSU commit pipe timing-clean.

Parameters:
- NUM_REQS, 2, number of requesters; must be ≥ 2.
- NUM_LANES, 4, lanes per request (equals NUM_THREADS).
- ADDRW, 30, word address width.
- DATAW, 32, lane data width.
- TAG_IN_W, 12, requester tag width.
- SEL_W, derived, max(1, CLOG2(NUM_REQS)).
- TAG_OUT_W, derived, TAG_IN_W + SEL_W.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid_in  in  NUM_REQS*NUM_LANES  per-requester per-lane valid
- req_rw_in  in  NUM_REQS*NUM_LANES  1 = write
- req_addr_in  in  NUM_REQS*NUM_LANES*ADDRW  word address
- req_byteen_in  in  NUM_REQS*NUM_LANES*4  byte enables
- req_data_in  in  NUM_REQS*NUM_LANES*DATAW  write data
- req_tag_in  in  NUM_REQS*NUM_LANES*TAG_IN_W  requester tag
- req_ready_out  out  NUM_REQS*NUM_LANES  per-lane accept
- dc_req_valid  out  NUM_LANES  cache request valid
- dc_req_rw  out  NUM_LANES  cache request rw
- dc_req_addr  out  NUM_LANES*ADDRW  cache request address
- dc_req_byteen  out  NUM_LANES*4  cache request byte enables
- dc_req_data  out  NUM_LANES*DATAW  cache request data
- dc_req_tag  out  NUM_LANES*TAG_OUT_W  {tag_in, sel}
- dc_req_ready  in  NUM_LANES  cache per-lane ready
- dc_rsp_valid  in  1  cache response valid
- dc_rsp_tmask  in  NUM_LANES  response lane mask
- dc_rsp_data  in  NUM_LANES*DATAW  response data
- dc_rsp_tag  in  TAG_OUT_W  response tag
- dc_rsp_ready  out  1  response accept
- rsp_valid_out  out  NUM_REQS  per-requester response valid
- rsp_tmask_out  out  NUM_LANES  registered lane mask
- rsp_data_out  out  NUM_LANES*DATAW  registered data
- rsp_tag_out  out  TAG_IN_W  registered tag, sel stripped
- rsp_ready_in  in  NUM_REQS  requester ready

Behaviour:
- A requester is active when any of its lanes is valid.
- Unlocked arbitration: round-robin over active requesters, starting at rr_ptr.
  - rr_ptr resets to 0.
  - After a requester's request completes, rr_ptr = winner + 1 mod NUM_REQS.
- Grant mux:
  - dc_req_* = the granted requester's lanes; dc_req_tag[l] = {req_tag_in[g][l], SEL_W'(g)}.
  - req_ready_out[g][l] = dc_req_ready[l].
  - All other requesters' ready = 0.
- Lane fire = dc_req_valid[l] & dc_req_ready[l]. Completion occurs when every valid lane of the grant fires in the same cycle.
- Lock:
  - If the grant fires some but not all valid lanes, set locked = 1 and hold grant_q = g.
  - While locked, the grant is forced to grant_q, ignoring other requesters, and rr_ptr does not move.
  - Locked clears on the cycle the remaining lanes all fire.
  - If the locked requester drops every lane without firing, locked clears the next cycle and rr_ptr is unchanged (protocol violation; asserted in simulation).
- No active requester: dc_req_valid = 0 and the state holds.
- Response stage, one entry (r_valid, r_sel, r_tmask, r_data, r_tag):
  - dc_rsp_ready = ~r_valid | rsp_ready_in[r_sel].
  - When dc_rsp_valid & dc_rsp_ready, load the entry with sel = dc_rsp_tag[SEL_W-1:0].
  - rsp_valid_out[i] = r_valid & (r_sel == i).
  - Latency is exactly 1 cycle. A simultaneous pop and push keeps full throughput.
  - A sel value ≥ NUM_REQS is dropped and asserted in simulation.
- Reset values:
  - rr_ptr = 0, locked = 0, grant_q = 0.
  - r_valid = 0, so all rsp_valid_out = 0 and dc_rsp_ready = 1.
  - dc_req_valid = 0 whenever all req_valid_in = 0.
  - Reset mid-lock drops the lock. Requesters re-present their unsent lanes; already-fired lanes are not replayed.

Decomposition:
- Shared package holds the per-lane request struct, per-lane response struct and SEL_W calculation.
- Natural sub-module: rr_lock_arbiter. It takes the active vector, the completion pulse and a partial-fire pulse, and outputs the grant index and one-hot grant. The datapath muxes stay in the top module.

Test Plan:
- Single requester: requester 0 presents lanes 1111 with tags 0x005 and all dc_req_ready = 1. In the same cycle dc_req_valid = 1111 and dc_req_tag = {0x005, 0}. Next grant with both active goes to requester 1.
- Contention, round-robin: both requesters active continuously with full readiness. Grants alternate 0, 1, 0, 1 for 4 cycles.
- Partial lock: requester 0 lanes 1111, dc_req_ready = 0011.
  - Lanes 0 and 1 fire.
  - Next cycle requester 0 presents 1100 and stays granted although requester 1 is active.
  - When ready = 1100, lanes 2 and 3 fire, the lock clears, and the following grant goes to requester 1.
- Response routing: dc_rsp_valid with tag {0x0A3, 1}, tmask 0101 and data 0xDEADBEEF. The next cycle gives rsp_valid_out = 10, rsp_tag_out = 0x0A3 and tmask 0101.
- Response backpressure: the entry holds a response for requester 1 with rsp_ready_in = 00. dc_rsp_ready = 0 and the entry holds stable. Raising rsp_ready_in[1] while a new response for requester 0 arrives pops and reloads in one cycle, giving rsp_valid_out = 01 next.
- Reset: assert reset during a lock with a response buffered. The next cycle shows rsp_valid_out = 0, dc_rsp_ready = 1 and arbitration starting at requester 0.
